// File: rtl/yuv_ctrl.sv
// yuv_ctrl: sequences the shared multiply/add RGB-to-YUV datapath, one pixel per 12 cycles.
// Optional schedule stall input `hold` is compiled in with YUV_CTRL_HOLD_EN.
module yuv_ctrl #(
   parameter int FRAME_PIXELS = 64,
   parameter int CNT_W        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef YUV_CTRL_HOLD_EN
   input  logic        hold,
`endif
   input  logic        in_valid,
   output logic        in_ready,
   output logic [21:0] control,
   output logic        done,
   output logic        out_valid,
   output logic        frame_done,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, T1, T2, T3, T4, T5, T6, T7, T8, T9, T10, T11, DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST      = CNT_W'(FRAME_PIXELS - 1);
   localparam logic [21:0]      LOAD_WORD = 22'h380000;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             hold_int;
   logic             stall;
   logic             accept;
   logic [21:0]      step_cw;
   logic [2:0]       prev_addr;

`ifdef YUV_CTRL_HOLD_EN
   assign hold_int = hold;
`else
   assign hold_int = 1'b0;
`endif

   // Field order: loads R1..R6, ROM addr, M1, M2, M3, M4, M5, M6, M7, M8, M9.
   function automatic logic [21:0] cw(input logic [5:0] ld, input logic [2:0] addr,
                                      input logic [1:0] m1, input logic [1:0] m2,
                                      input logic [1:0] m3, input logic m4,
                                      input logic [1:0] m5, input logic m6,
                                      input logic m7, input logic m8, input logic m9);
      return {ld, addr, m1, m2, m3, m4, m5, m6, m7, m8, m9};
   endfunction

   // prev_addr is what the previous step issued; re-issuing it keeps the ROM output valid during a stall.
   always_comb begin
      step_cw   = '0;
      prev_addr = 3'd0;
      case (state)
         T1:  begin step_cw = cw(6'b000100, 3'd3, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); prev_addr = 3'd0; end
         T2:  begin step_cw = cw(6'b000010, 3'd5, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); prev_addr = 3'd3; end
         T3:  begin step_cw = cw(6'b000001, 3'd1, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); prev_addr = 3'd5; end
         T4:  begin step_cw = cw(6'b100010, 3'd4, 2'd1, 2'd0, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); prev_addr = 3'd1; end
         T5:  begin step_cw = cw(6'b000110, 3'd6, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0); prev_addr = 3'd4; end
         T6:  begin step_cw = cw(6'b100010, 3'd2, 2'd1, 2'd3, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); prev_addr = 3'd6; end
         T7:  begin step_cw = cw(6'b000011, 3'd5, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1); prev_addr = 3'd2; end
         T8:  begin step_cw = cw(6'b010010, 3'd7, 2'd0, 2'd2, 2'd3, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0); prev_addr = 3'd5; end
         T9:  begin step_cw = cw(6'b100010, 3'd0, 2'd0, 2'd3, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); prev_addr = 3'd7; end
         T10: begin step_cw = cw(6'b000001, 3'd0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1); prev_addr = 3'd0; end
         T11: begin step_cw = cw(6'b001000, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); prev_addr = 3'd0; end
         default: begin step_cw = '0; prev_addr = 3'd0; end
      endcase
   end

   assign stall    = hold_int && (state != IDLE);
   assign in_ready = rst_n && !hold_int && ((state == IDLE) || (state == DONE));
   assign accept   = in_ready && in_valid;
   assign done     = (state == DONE) && !stall;
   assign busy     = (state != IDLE);

   always_comb begin
      control = '0;
      if (accept)
         control = LOAD_WORD;
      else if (stall)
         control = {6'b000000, prev_addr, step_cw[12:0]};
      else
         control = step_cw;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= done;
         frame_done <= done && (count == LAST);
         if (done)
            count <= (count == LAST) ? '0 : count + 1'b1;
         if (accept)
            state <= T1;
         else if (!stall) begin
            case (state)
               IDLE:    state <= IDLE;
               T11:     state <= DONE;
               DONE:    state <= IDLE;
               default: state <= state_t'(state + 4'd1);
            endcase
         end
      end
   end

endmodule

// File: tb/tb_yuv_ctrl.sv
// Bench for yuv_ctrl: drives a behavioural datapath from the control word and scoreboards Y/U/V.
module tb_yuv_ctrl;

   localparam int FP = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [21:0] control;
   logic        done;
   logic        out_valid;
   logic        frame_done;
   logic        busy;
`ifdef YUV_CTRL_HOLD_EN
   logic        hold = 1'b0;
`endif

   yuv_ctrl #(.FRAME_PIXELS(FP), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef YUV_CTRL_HOLD_EN
      .hold(hold),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .control(control), .done(done),
      .out_valid(out_valid), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
      end
   endfunction

   // Datapath model: executes whatever control word the DUT presented in the cycle just ending.
   int rom [8] = '{77, 150, 29, -43, -85, 128, -107, -21};
   int pr, pg, pb;
   int r1, r2, r3, r4, r5, r6, rom_q, yo, uo, vo;
   logic [21:0] ctl_q = '0;
   logic        done_q = 1'b0;

   always @(negedge clk) begin
      ctl_q  <= control;
      done_q <= done;
   end

   always @(posedge clk) begin
      int a, b, c, fmul, fadd;
      a = (ctl_q[12:11] == 2) ? r1 : (ctl_q[12:11] == 1) ? r2 : r3;
      case (ctl_q[10:9]) 2'd0: b = 128; 2'd1: b = r5; 2'd2: b = r4; default: b = r1; endcase
      case (ctl_q[8:7])  2'd0: c = r6;  2'd1: c = r3; 2'd2: c = r2; default: c = r5; endcase
      fmul = a * rom_q;
      fadd = b + c;
      if (ctl_q[21]) r1 <= ctl_q[6] ? fadd : pr;
      if (ctl_q[20]) r2 <= (ctl_q[5:4] == 0) ? pg : (ctl_q[5:4] == 1) ? fmul : fadd;
      if (ctl_q[19]) r3 <= ctl_q[3] ? fadd : pb;
      if (ctl_q[18]) r4 <= ctl_q[2] ? fadd : fmul;
      if (ctl_q[17]) r5 <= ctl_q[1] ? fadd : fmul;
      if (ctl_q[16]) r6 <= ctl_q[0] ? fadd : fmul;
      rom_q <= rom[ctl_q[15:13]];
      if (done_q) begin
         yo <= r2;
         uo <= r1;
         vo <= r3;
      end
   end

   typedef struct { int y; int u; int v; int due; } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   int   pix_idx = 0;
   int   last_acc = 0;

   // Reference: plain weighted sums with the coefficient table above.
   task automatic push(input int r, input int g, input int b, input int extra);
      exp_t e;
      e.y   = r * 77 + g * 150 + b * 29;
      e.u   = 128 + r * (-43) + g * (-85) + b * 128;
      e.v   = 128 + r * 128 + g * (-107) + b * (-21);
      e.due = cyc + 13 + extra;
      last_acc = cyc;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
            else                   chk("done_cycle", cyc + 1, exp_q[0].due);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) chk("out_valid_unexpected", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               chk("y", yo, mon_e.y);
               chk("u", uo, mon_e.u);
               chk("v", vo, mon_e.v);
               chk("out_valid_cycle", cyc, mon_e.due);
               chk("frame_done", frame_done, (pix_idx % FP) == FP - 1);
               pix_idx++;
            end
         end else begin
            chk("frame_done_without_out_valid", frame_done, 0);
            if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
               chk("out_valid_missing", 0, 1);
               void'(exp_q.pop_front());
               pix_idx++;
            end
         end
      end
   end

   task automatic send(input int r, input int g, input int b, input int extra);
      bit ok = 1'b0;
      pr = r; pg = g; pb = b;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            push(r, g, b, extra);
            ok = 1'b1;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_pending", exp_q.size(), 0);
   endtask

   logic [21:0] sched [12];
   initial begin
      sched = '{22'h380000, 22'h047000, 22'h02B000, 22'h013000, 22'h2289C0, 22'h06CD84,
                22'h224FC0, 22'h03A201, 22'h12E5A0, 22'h2207C0, 22'h010201, 22'h080008};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_acc;
      rst_n = 1'b0; in_valid = 1'b0; pr = 0; pg = 0; pb = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_control", control, 0);
      chk("rst_done", done, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_control", control, 0);

      // First pixel (black): full schedule walk, in_valid left high through T10 to prove it is ignored.
      @(posedge clk); #1;
      pr = 0; pg = 0; pb = 0; in_valid = 1'b1;
      @(negedge clk);
      chk("sched_load", control, sched[0]);
      push(0, 0, 0, 0);
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         if (k == 11) in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("sched_t%0d", k), control, sched[k]);
         chk("busy_in_step", busy, 1);
         chk("in_ready_in_step", in_ready, 0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_control", control, 0);
      chk("done_busy", busy, 1);
      chk("done_in_ready", in_ready, 1);
      drain();

      send(255, 0, 0, 0);
      send(255, 255, 255, 0);
      drain();

      for (int i = 0; i < 5; i++) begin
         send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #1;
      end
      drain();

      // Continuous in_valid: every send lands in the DONE cycle of the previous pixel.
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
      for (int i = 0; i < 4; i++) begin
         prev_acc = last_acc;
         send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
         chk("b2b_spacing", last_acc - prev_acc, 12);
      end
      drain();

      // Asynchronous reset in T6.
      send(100, 150, 200, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("t6_before_reset", control, sched[6]);
      rst_n = 1'b0;
      #1;
      chk("async_rst_control", control, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      exp_q.delete();
      pix_idx = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("no_out_valid_after_rst", out_valid, 0);
         chk("no_done_after_rst", done, 0);
      end
      @(posedge clk); #1;
      send(10, 20, 30, 0);
      @(negedge clk);
      chk("restart_t1", control, sched[1]);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
         send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
      drain();

`ifdef YUV_CTRL_HOLD_EN
      send(37, 201, 90, 3);
      repeat (3) @(posedge clk);
      #1;
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_loads", control[21:16], 0);
         chk("hold_addr", control[15:13], 1);
         chk("hold_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      hold = 1'b0;
      @(negedge clk);
      chk("hold_resume_t4", control, sched[4]);
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
